bnn_layer_seq: RTL
==================

Name: bnn_layer_seq

Overview:
- Parametrised, pipelined binary neural network layer. Successor to the fixed 6-input / 4-neuron combinational BNN core.
- Computes an XNOR-popcount and threshold activation for N_NEU neurons over an N_IN-bit binary input vector.
- Weights and thresholds are runtime-loadable through a sequenced config port. Data moves through a 2-stage valid/ready pipeline with backpressure.
- Sits between the pin-level input capture logic and the output mux in tt_um top-levels.

Parameters:
- N_IN, 6: input vector width and weight width per neuron (>=2).
- N_NEU, 4: number of neurons / output bits (>=1).
- CW, $clog2(N_IN+1): popcount and threshold width (derived; do not override).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous reset, active-high.
- cfg_start, input, 1: begin load sequence (pulse).
- cfg_valid, input, 1: cfg_data word valid.
- cfg_data, input, N_IN: weight word, or threshold in [CW-1:0] (upper bits ignored).
- cfg_busy, output, 1: high while in LOAD state.
- cfg_done, output, 1: 1-cycle pulse after the last config word is accepted.
- mode, input, 1: 0 = per-neuron threshold; 1 = majority (2*sum >= N_IN), thresholds ignored.
- in_valid, input, 1: input vector valid.
- in_ready, output, 1: layer accepts input.
- in_data, input, N_IN: binary input vector.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts result.
- out_bits, output, N_NEU: activation; bit k = neuron k.
- out_sums, output, N_NEU*CW: popcounts; neuron k at [k*CW +: CW].

Behaviour:
- Reset values:
  - Weights: all 0.
  - Thresholds: ceil(N_IN/2) (3 for the defaults).
  - State: RUN; load pointer 0.
  - cfg_busy=0, cfg_done=0, out_valid=0, out_bits=0, out_sums=0, internal s1_valid=0.
- States:
  - RUN: normal operation.
  - LOAD: accepting config words.
- RUN -> LOAD: cfg_start=1 while s1_valid=0 and out_valid=0. Otherwise cfg_start is ignored. This guarantees no in-flight data ever sees mixed coefficients.
- LOAD sequence:
  - Pointer p runs 0 .. 2*N_NEU-1. Each cycle with cfg_valid=1 writes one word, then p++.
  - p < N_NEU: writes weight[p] = cfg_data.
  - p >= N_NEU: writes threshold[p-N_NEU] = cfg_data[CW-1:0].
  - After the word at p = 2*N_NEU-1: cfg_done pulses the next cycle, the state returns to RUN, and p clears.
  - cfg_start during LOAD restarts with p=0. Words already written are kept.
- In LOAD: in_ready=0 and in_valid is ignored. In RUN: cfg_valid is ignored.
- Pipeline:
  - Stage 1 registers sum[k] = popcount(in_data XNOR weight[k]) for every k, plus s1_valid.
  - Stage 2 registers out_sums and out_bits from the stage-1 sums, plus out_valid.
  - Activation: mode=0 gives out_bits[k] = sum[k] >= threshold[k] (unsigned compare, CW bits). mode=1 gives {sum[k],1'b0} >= N_IN.
  - mode is sampled at stage 2.
- Latency: 2 cycles from the in handshake to out_valid. Throughput: 1 vector per cycle when out_ready=1.
- Handshake rules:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = (state==RUN) & adv1.
  - out_valid, out_bits and out_sums hold stable while out_valid & !out_ready.
  - Ordering is preserved; no drops and no duplicates.
- Threshold boundaries:
  - Threshold 0: neuron output is always 1.
  - Threshold > N_IN (e.g. 7 when N_IN=6): neuron output is always 0.
  - Popcount never overflows CW.
- Reset mid-LOAD or mid-pipeline: everything returns immediately to the reset values above, and partial loads are discarded.

Test Plan:
- Reset defaults:
  - in_data=6'b000000 -> 2 cycles later out_valid=1, sums {6,6,6,6}, out_bits=4'b1111.
  - in_data=6'b111111 -> sums 0, out_bits=4'b0000.
- Load and compute:
  - cfg_start, then weights 111000, 000111, 001100, 110011, then thresholds 2,2,2,2 -> cfg_done pulses once, cfg_busy falls.
  - in_data=111000 -> sums (n0..n3) {6,0,3,3}, out_bits=4'b1101.
- Mode: reload with thresholds 4,4,4,4, in_data=111000:
  - mode=0 -> out_bits=4'b0001.
  - mode=1 -> out_bits=4'b1101.
- Backpressure: hold out_ready=0, offer 3 vectors back-to-back:
  - Exactly 2 are accepted; in_ready=0 afterwards; outputs are held stable.
  - Raise out_ready -> all 3 results appear in order with no gaps.
- Boundaries:
  - Thresholds 0 and 7 -> those neurons are constant 1 and 0 respectively.
  - cfg_start asserted while out_valid=1 -> ignored (cfg_busy stays 0).
- Reset mid-LOAD: assert reset after 2 weight words -> weights return to 0 and thresholds to 3, and the next in_data=000000 gives out_bits=4'b1111.

Source files
------------

// File: rtl/bnn_layer_seq.sv
//==============================================================================
// Module   : bnn_layer_seq
// Purpose  : Pipelined XNOR-popcount binary NN layer with runtime-loadable
//            weights/thresholds and a 2-stage valid/ready datapath.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module bnn_layer_seq #(
  parameter int N_IN  = 6,
  parameter int N_NEU = 4,
  parameter int CW    = $clog2(N_IN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [N_IN-1:0]       cfg_data,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_NEU-1:0]      out_bits,
  output logic [N_NEU*CW-1:0]   out_sums
);

  localparam int              PW        = $clog2(2 * N_NEU);
  localparam logic [PW-1:0]   C_LAST    = PW'(2 * N_NEU - 1);
  localparam logic [CW-1:0]   C_THR_RST = CW'((N_IN + 1) / 2);
  localparam logic [CW:0]     C_NIN     = (CW+1)'(N_IN);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_ptr;
  logic                r_done;
  logic [N_IN-1:0]     r_weight [N_NEU];
  logic [CW-1:0]       r_thresh [N_NEU];
  logic                r_s1_valid;
  logic [CW-1:0]       r_s1_sum [N_NEU];

  logic                w_adv1;
  logic                w_adv2;
  logic                w_in_fire;
  logic                w_cfg_go;

  function automatic logic [CW-1:0] f_popcnt(input logic [N_IN-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic f_act(input logic [CW-1:0] sum, input logic [CW-1:0] thr,
                                 input logic m);
    if (m) return ({sum, 1'b0} >= C_NIN);
    return (sum >= thr);
  endfunction

  assign w_adv2    = !out_valid | out_ready;
  assign w_adv1    = !r_s1_valid | w_adv2;
  assign in_ready  = (r_state == ST_RUN) & w_adv1;
  assign w_in_fire = in_valid & in_ready;
  // A vector entering stage 1 this very cycle also counts as in flight.
  assign w_cfg_go  = cfg_start & !r_s1_valid & !out_valid & !w_in_fire;

  assign cfg_busy  = (r_state == ST_LOAD);
  assign cfg_done  = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_ptr   <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < N_NEU; k++) begin
        r_weight[k] <= '0;
        r_thresh[k] <= C_THR_RST;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (w_cfg_go) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            r_ptr <= '0;
          end else if (cfg_valid) begin
            for (int k = 0; k < N_NEU; k++) begin
              if (r_ptr == PW'(k))         r_weight[k] <= cfg_data;
              if (r_ptr == PW'(N_NEU + k)) r_thresh[k] <= cfg_data[CW-1:0];
            end
            if (r_ptr == C_LAST) begin
              r_state <= ST_RUN;
              r_ptr   <= '0;
              r_done  <= 1'b1;
            end else begin
              r_ptr <= r_ptr + PW'(1);
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_bits   <= '0;
      out_sums   <= '0;
      for (int k = 0; k < N_NEU; k++) r_s1_sum[k] <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= w_in_fire;
        if (w_in_fire) begin
          for (int k = 0; k < N_NEU; k++)
            r_s1_sum[k] <= f_popcnt(~(in_data ^ r_weight[k]));
        end
      end
      if (w_adv2) begin
        out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          for (int k = 0; k < N_NEU; k++) begin
            out_sums[k*CW +: CW] <= r_s1_sum[k];
            out_bits[k]          <= f_act(r_s1_sum[k], r_thresh[k], mode);
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
